// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - packed output beat stream interface
//
// Carries the packed output beat from fifo_rd_packer to its consumer.
//   m_valid : beat valid (master -> slave)
//   m_ready : consumer ready (slave -> master)
//   m_data  : FIFO_WIDTH*PACK packed beat, word 0 at the LSBs
//   m_keep  : PACK per-word valid mask
interface fifo_rd_packer_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int PACK       = 2
);
  logic                       m_valid;
  logic                       m_ready;
  logic [FIFO_WIDTH*PACK-1:0] m_data;
  logic [PACK-1:0]            m_keep;

  modport master (output m_valid, m_data, m_keep, input m_ready);
  modport slave  (input m_valid, m_data, m_keep, output m_ready);
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - drains a 1-cycle-latency FIFO read port and packs PACK words per beat
//
// Optional feature macro: ADAPTER_FLUSH_EN (adds the flush port for partial beats).
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (shared with the FIFO)
//   fifo_empty      : FIFO empty flag
//   fifo_data_out   : FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en      : combinational read request to the FIFO
//   m               : packed beat stream (m_valid/m_ready/m_data/m_keep)
//   beat_cnt        : count of accepted beats, wraps at 2^CNT_W
//   flush           : partial-beat flush request (ADAPTER_FLUSH_EN only)
module fifo_rd_packer #(
  parameter int FIFO_WIDTH = 16,
  parameter int PACK       = 2,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_rd_packer_if.master      m,
  output logic [CNT_W-1:0]      beat_cnt
`ifdef ADAPTER_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int FILL_W = $clog2(PACK + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PACK);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PACK - 1);

  typedef enum logic { OBUF_EMPTY = 1'b0, OBUF_FULL = 1'b1 } obuf_state_t;

  obuf_state_t                state_q, state_d;
  logic [FILL_W-1:0]          fill_cnt, fill_d;
  logic                       inflight;
  logic [FIFO_WIDTH*PACK-1:0] asm_q;
  logic [FIFO_WIDTH*PACK-1:0] obuf_data;
  logic [PACK-1:0]            obuf_keep;

  logic                       capture, accept, obuf_free;
  logic                       full_xfer, flush_xfer, transfer;
  logic                       asm_wr;
  logic [FILL_W-1:0]          asm_slot;
  logic [FIFO_WIDTH*PACK-1:0] xfer_data;
  logic [PACK-1:0]            xfer_keep;

  assign m.m_valid = (state_q == OBUF_FULL);
  assign m.m_data  = obuf_data;
  assign m.m_keep  = obuf_keep;

  always_comb begin
    capture    = inflight;
    accept     = (state_q == OBUF_FULL) && m.m_ready;
    obuf_free  = (state_q == OBUF_EMPTY) || m.m_ready;

    // The assembly counts as full either when it already holds PACK words or
    // when the word landing this cycle completes it; the latter lets the last
    // word bypass straight into obuf so the read latency stays hidden.
    full_xfer  = (fill_cnt == FILL_FULL) || (capture && (fill_cnt == FILL_LAST));

`ifdef ADAPTER_FLUSH_EN
    flush_xfer = flush && (fill_cnt != '0) && !inflight && obuf_free;
`else
    flush_xfer = 1'b0;
`endif

    transfer   = (full_xfer && obuf_free) || flush_xfer;

    fifo_rd_en = rst_n && !fifo_empty && !flush_xfer &&
                 (((int'(fill_cnt) + int'(inflight)) < PACK) || transfer);

    // Beat image: stored words below fill_cnt, the landing word at fill_cnt,
    // zeros elsewhere so a flushed partial beat carries no stale data.
    xfer_data = '0;
    xfer_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (i < int'(fill_cnt)) begin
        xfer_data[i*FIFO_WIDTH +: FIFO_WIDTH] = asm_q[i*FIFO_WIDTH +: FIFO_WIDTH];
        xfer_keep[i] = 1'b1;
      end else if (capture && (i == int'(fill_cnt))) begin
        xfer_data[i*FIFO_WIDTH +: FIFO_WIDTH] = fifo_data_out;
        xfer_keep[i] = 1'b1;
      end
    end

    // A captured word is stored unless it bypassed into obuf; when a full
    // assembly leaves while a word lands, that word starts the next beat.
    asm_wr   = capture && (!transfer || (fill_cnt == FILL_FULL));
    asm_slot = transfer ? '0 : fill_cnt;

    fill_d = fill_cnt;
    if (transfer) begin
      fill_d = (capture && (fill_cnt == FILL_FULL)) ? FILL_W'(1) : '0;
    end else if (capture) begin
      fill_d = fill_cnt + FILL_W'(1);
    end

    state_d = state_q;
    case (state_q)
      OBUF_EMPTY: if (transfer) state_d = OBUF_FULL;
      OBUF_FULL:  if (accept && !transfer) state_d = OBUF_EMPTY;
      default:    state_d = OBUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OBUF_EMPTY;
      fill_cnt  <= '0;
      inflight  <= 1'b0;
      asm_q     <= '0;
      obuf_data <= '0;
      obuf_keep <= '0;
      beat_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      fill_cnt <= fill_d;
      inflight <= fifo_rd_en;
      if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (transfer) begin
        obuf_data <= xfer_data;
        obuf_keep <= xfer_keep;
      end
      for (int i = 0; i < PACK; i++) begin
        if (asm_wr && (i == int'(asm_slot))) begin
          asm_q[i*FIFO_WIDTH +: FIFO_WIDTH] <= fifo_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [15:0] fifo_data_out;
  logic        fifo_rd_en;
  logic [3:0]  beat_cnt;
`ifdef ADAPTER_FLUSH_EN
  logic        flush;
`endif

  fifo_rd_packer_if #(.FIFO_WIDTH(16), .PACK(2)) m_if ();

  fifo_rd_packer #(.FIFO_WIDTH(16), .PACK(2), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .m             (m_if),
    .beat_cnt      (beat_cnt)
`ifdef ADAPTER_FLUSH_EN
    ,
    .flush         (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: 1-cycle read latency, contents discarded on reset.
  logic [15:0] fmem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= wr_ptr;
      fifo_data_out <= '0;
    end else if (fifo_rd_en) begin
      fifo_data_out <= fmem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [15:0] w);
    fmem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Accepted-beat log and read-while-empty watch, sampled mid-cycle.
  logic [31:0] got [$];
  int rd_violations = 0;
  always @(negedge clk) begin
    if (rst_n && m_if.m_valid && m_if.m_ready) got.push_back(m_if.m_data);
    if (rst_n && fifo_rd_en && fifo_empty) rd_violations++;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] got_at(input int idx);
    if (idx < got.size()) return got[idx];
    return 32'hxxxx_xxxx;
  endfunction

  initial begin
    rst_n          = 1'b0;
    m_if.m_ready   = 1'b0;
`ifdef ADAPTER_FLUSH_EN
    flush          = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(m_if.m_valid), 64'd0);
    check("rst_data",  64'(m_if.m_data),  64'd0);
    check("rst_keep",  64'(m_if.m_keep),  64'd0);
    check("rst_cnt",   64'(beat_cnt),     64'd0);
    check("rst_rd_en", 64'(fifo_rd_en),   64'd0);
    rst_n = 1'b1;
    tick();

    // Streaming: eight words, ready held high.
    m_if.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    #1;
    check("strm_rd_c0", 64'(fifo_rd_en), 64'd1);
    repeat (3) tick();
    check("strm_valid_c3", 64'(m_if.m_valid), 64'd1);
    check("strm_beat0",    64'(m_if.m_data),  64'h0002_0001);
    check("strm_keep0",    64'(m_if.m_keep),  64'h3);
    tick();
    check("strm_gap_c4",   64'(m_if.m_valid), 64'd0);
    tick();
    check("strm_beat1",    64'(m_if.m_data),  64'h0004_0003);
    repeat (8) tick();
    check("strm_nbeats",   64'(got.size()),   64'd4);
    check("strm_beat2",    64'(got_at(2)),    64'h0006_0005);
    check("strm_beat3",    64'(got_at(3)),    64'h0008_0007);
    check("strm_cnt",      64'(beat_cnt),     64'd4);

    // Backpressure: six words, consumer stalled for ten cycles.
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(16'hA000 + 16'(i));
    repeat (10) tick();
    check("bp_valid",  64'(m_if.m_valid), 64'd1);
    check("bp_hold",   64'(m_if.m_data),  64'hA001_A000);
    check("bp_rd_off", 64'(fifo_rd_en),   64'd0);
    check("bp_fill",   64'(dut.fill_cnt), 64'd2);
    m_if.m_ready = 1'b1;
    repeat (10) tick();
    check("bp_nbeats", 64'(got.size()),   64'd7);
    check("bp_beat0",  64'(got_at(4)),    64'hA001_A000);
    check("bp_beat1",  64'(got_at(5)),    64'hA003_A002);
    check("bp_beat2",  64'(got_at(6)),    64'hA005_A004);

    // Empty edge: a lone word waits in assembly for its partner.
    push(16'h1234);
    repeat (4) tick();
    check("edge_valid", 64'(m_if.m_valid), 64'd0);
    check("edge_fill",  64'(dut.fill_cnt), 64'd1);
    push(16'h5678);
    repeat (4) tick();
    check("edge_nbeats", 64'(got.size()), 64'd8);
    check("edge_beat",   64'(got_at(7)),  64'h5678_1234);

    // Reset mid-fill: outputs clear immediately, partial word is lost.
    push(16'hDEAD);
    repeat (3) tick();
    check("mid_fill", 64'(dut.fill_cnt), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(m_if.m_valid), 64'd0);
    check("arst_data",  64'(m_if.m_data),  64'd0);
    check("arst_cnt",   64'(beat_cnt),     64'd0);
    check("arst_fill",  64'(dut.fill_cnt), 64'd0);
    push(16'h9999);
    #1;
    check("arst_fifo_nonempty", 64'(fifo_empty), 64'd0);
    check("arst_rd_en",         64'(fifo_rd_en), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    push(16'h1111);
    push(16'h2222);
    repeat (6) tick();
    check("post_rst_nbeats", 64'(got.size()), 64'd9);
    check("post_rst_beat",   64'(got_at(8)),  64'h2222_1111);
    check("post_rst_cnt",    64'(beat_cnt),   64'd1);

    // beat_cnt wrap: sixteen more beats gives 17 since reset.
    for (int i = 0; i < 32; i++) push(16'h0100 + 16'(i));
    repeat (45) tick();
    check("wrap_nbeats", 64'(got.size()), 64'd25);
    check("wrap_last",   64'(got_at(24)), 64'h011F_011E);
    check("wrap_cnt",    64'(beat_cnt),   64'd1);

`ifdef ADAPTER_FLUSH_EN
    push(16'hBEEF);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(m_if.m_valid), 64'd1);
    check("flush_data",  64'(m_if.m_data),  64'h0000_BEEF);
    check("flush_keep",  64'(m_if.m_keep),  64'h1);
    tick();
    flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0;
    check("flush_empty_ignored", 64'(m_if.m_valid), 64'd0);
    check("flush_nbeats",        64'(got.size()),   64'd26);
`endif

    check("rd_while_empty", 64'(rd_violations), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
